change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Change-payout controller for the retro vending machine. It tracks the coin-tube inventory for 5/10/25-cent coins from accepted-coin pulses. On request, it pays a change amount by sequencing eject requests to the coin hopper under a req/ack handshake, using greedy largest-coin-first selection. It sits between the vending FSM, which issues the change request after a dispense, and the hopper mechanics.

Parameters:
TUBE_MAX, 15, tube capacity in coins per denomination
CNT_W, 4, tube count width; must hold TUBE_MAX
AMT_W, 8, change amount width in cents
ACK_TIMEOUT, 15, cycles an eject may wait for ack before fault

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
coin_5  in  1  one-cycle pulse: accepted 5c coin routed to tube
coin_10  in  1  one-cycle pulse: accepted 10c coin
coin_25  in  1  one-cycle pulse: accepted 25c coin
chg_valid  in  1  change request valid
chg_amount  in  AMT_W  change to pay, in cents
chg_ready  out  1  block can accept a request
eject_5  out  1  hopper eject request, 5c, held until ack
eject_10  out  1  hopper eject request, 10c
eject_25  out  1  hopper eject request, 25c
eject_ack  in  1  hopper has ejected the requested coin
chg_done  out  1  one-cycle pulse: payout finished
chg_short  out  1  valid with chg_done: remainder was nonzero
chg_remain  out  AMT_W  unpaid cents, held until next accept
overflow  out  1  one-cycle pulse: coin arrived at full tube, routed to cashbox
fault  out  1  sticky: hopper ack timeout
tube_5  out  CNT_W  5c coin count
tube_10  out  CNT_W  10c coin count
tube_25  out  CNT_W  25c coin count

Behaviour:
- Reset: state IDLE. All eject_*, chg_done, chg_short, overflow and fault are 0. chg_remain=0 and tube counts=0. chg_ready=1 from the first cycle after reset.
- chg_ready = (state==IDLE) && !fault.
- States are IDLE, PICK, EJECT, DONE and FAULT.
- IDLE: a request is accepted when chg_valid && chg_ready at an edge. On accept, rem <= chg_amount, then go to PICK. chg_valid is ignored in every other state.
- PICK, one cycle, greedy selection:
  - rem>=25 and tube_25>0 -> 25c
  - else rem>=10 and tube_10>0 -> 10c
  - else rem>=5 and tube_5>0 -> 5c
  - else go to DONE.
  - If a coin was chosen, register it and go to EJECT.
- EJECT: hold exactly one eject_* high, one-hot and registered.
  - On eject_ack: drop eject the next cycle, decrement that tube, rem -= denomination, go to PICK.
  - eject_ack in any other state is ignored.
- Timeout: a counter clears on entering EJECT. If it reaches ACK_TIMEOUT without ack: eject low, fault=1, go to FAULT. No chg_done is issued, and rem is copied to chg_remain.
- FAULT: terminal. chg_ready=0 and coin counting continues. Only reset exits.
- DONE, one cycle: chg_done=1, chg_short=(rem!=0), chg_remain=rem, then IDLE.
- Latency:
  - Accept at edge N: PICK in cycle N+1, eject_* high from N+2.
  - If no coin is payable, chg_done is high in cycle N+2.
- Amounts that are not a multiple of 5 always end short, with a remainder of at least 1.
- Greedy selection is not optimal by design. Example: 30 with tubes 25×1, 10×3 pays 25 and ends short with remain 5.
- Tube counting:
  - Each coin_x increments its tube independently; simultaneous pulses are all counted.
  - Increment at TUBE_MAX: count unchanged, overflow pulse next cycle.
  - Same-cycle increment and eject-ack decrement on one tube: count unchanged, no overflow.
- Reset mid-payout: eject_* low the cycle after reset is sampled low; no chg_done.

Decomposition:
- vend_pkg holds:
  - denomination constants DENOM_5/10/25
  - the coin-select enum (NONE, C5, C10, C25)
  - the payout state enum
- Sub-module coin_tube_counter: saturating up/down counter (inc, dec, count, overflow pulse), parameterised by TUBE_MAX and CNT_W, instantiated ×3.

Test Plan:
1. Load the tubes with 2×coin_25, 1×coin_10, 1×coin_5, then request 40 and ack each eject after 3 cycles.
   -> eject_25, eject_10, eject_5 in order, then chg_done=1, chg_short=0, chg_remain=0; tubes end 25:1, 10:0, 5:0.
2. All tubes empty, request 15 accepted at N.
   -> chg_done in N+2, chg_short=1, chg_remain=15, no eject_* ever high.
3. Tubes 25×1, 10×3, request 30.
   -> one eject_25, then done with short=1, remain=5, tube_10 still 3.
4. tube_10=1, request 10, ack withheld.
   -> eject_10 drops after 15 cycles, fault=1, chg_ready=0, no chg_done.
   -> after reset=0 for one edge: fault=0, chg_ready=1.
5. coin_25 pulsed in the same cycle as eject_ack for eject_25: tube_25 unchanged. Sixteen coin_5 pulses from empty: tube_5=15 and exactly one overflow pulse.
6. Request 25, then chg_valid=1 with amount 10 during EJECT: ignored, the payout completes for 25 only. A separate run with reset asserted during EJECT: eject low next cycle, no chg_done, counts 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the change-payout controller: coin values, coin select and payout states.
package vend_pkg;

    localparam int DENOM_5  = 5;
    localparam int DENOM_10 = 10;
    localparam int DENOM_25 = 25;

    typedef enum logic [1:0] {NONE, C5, C10, C25} coin_sel_e;

    typedef enum logic [2:0] {IDLE, PICK, EJECT, DONE, FAULT} pay_state_e;

endpackage

// File: rtl/coin_tube_counter.sv
// Saturating per-denomination tube counter; a coin arriving at a full tube is
// diverted to the cashbox and flagged with a one-cycle overflow pulse.
module coin_tube_counter #(
    parameter int TUBE_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = 1'b0;
        // A coin in and a coin out on the same edge cancel, even at a full tube.
        if (inc && !dec) begin
            if (count_q == CNT_W'(TUBE_MAX)) overflow_d = 1'b1;
            else                             count_d    = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/change_dispenser.sv
// Change-payout controller: tracks coin tubes and pays change greedily
// (largest coin first) through a req/ack handshake with the hopper.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int TUBE_MAX    = 15,
    parameter int CNT_W       = 4,
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_5,
    input  logic             coin_10,
    input  logic             coin_25,
    input  logic             chg_valid,
    input  logic [AMT_W-1:0] chg_amount,
    output logic             chg_ready,
    output logic             eject_5,
    output logic             eject_10,
    output logic             eject_25,
    input  logic             eject_ack,
    output logic             chg_done,
    output logic             chg_short,
    output logic [AMT_W-1:0] chg_remain,
    output logic             overflow,
    output logic             fault,
    output logic [CNT_W-1:0] tube_5,
    output logic [CNT_W-1:0] tube_10,
    output logic [CNT_W-1:0] tube_25
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    pay_state_e       state_q, state_d;
    coin_sel_e        sel_q, sel_d;
    logic [AMT_W-1:0] rem_q, rem_d, remain_q, remain_d, denom;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d, done_q, done_d, short_q, short_d;
    logic [2:0]       ej_q, ej_d;
    logic [2:0]       ovf;
    logic             ack_ok;

    assign ack_ok = (state_q == EJECT) && eject_ack;

    coin_tube_counter #(.TUBE_MAX(TUBE_MAX), .CNT_W(CNT_W)) u_tube_5 (
        .clk(clk), .reset(reset), .inc(coin_5), .dec(ack_ok && sel_q == C5),
        .count(tube_5), .overflow(ovf[0]));
    coin_tube_counter #(.TUBE_MAX(TUBE_MAX), .CNT_W(CNT_W)) u_tube_10 (
        .clk(clk), .reset(reset), .inc(coin_10), .dec(ack_ok && sel_q == C10),
        .count(tube_10), .overflow(ovf[1]));
    coin_tube_counter #(.TUBE_MAX(TUBE_MAX), .CNT_W(CNT_W)) u_tube_25 (
        .clk(clk), .reset(reset), .inc(coin_25), .dec(ack_ok && sel_q == C25),
        .count(tube_25), .overflow(ovf[2]));

    always_comb begin
        case (sel_q)
            C5:      denom = AMT_W'(DENOM_5);
            C10:     denom = AMT_W'(DENOM_10);
            C25:     denom = AMT_W'(DENOM_25);
            default: denom = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rem_d    = rem_q;
        remain_d = remain_q;
        tmo_d    = tmo_q;
        fault_d  = fault_q;
        ej_d     = ej_q;
        done_d   = 1'b0;
        short_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (chg_valid && !fault_q) begin
                    rem_d    = chg_amount;
                    remain_d = '0;
                    state_d  = PICK;
                end
            end
            PICK: begin
                tmo_d = '0;
                if (rem_q >= AMT_W'(DENOM_25) && tube_25 != '0) begin
                    sel_d = C25; ej_d = 3'b100; state_d = EJECT;
                end else if (rem_q >= AMT_W'(DENOM_10) && tube_10 != '0) begin
                    sel_d = C10; ej_d = 3'b010; state_d = EJECT;
                end else if (rem_q >= AMT_W'(DENOM_5) && tube_5 != '0) begin
                    sel_d = C5;  ej_d = 3'b001; state_d = EJECT;
                end else begin
                    // Done/short flags are registered here so they line up with the DONE cycle.
                    sel_d    = NONE;
                    done_d   = 1'b1;
                    short_d  = (rem_q != '0);
                    remain_d = rem_q;
                    state_d  = DONE;
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    ej_d    = 3'b000;
                    rem_d   = rem_q - denom;
                    state_d = PICK;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    ej_d     = 3'b000;
                    fault_d  = 1'b1;
                    remain_d = rem_q;
                    state_d  = FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= NONE;
            rem_q    <= '0;
            remain_q <= '0;
            tmo_q    <= '0;
            fault_q  <= 1'b0;
            ej_q     <= 3'b000;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
            remain_q <= remain_d;
            tmo_q    <= tmo_d;
            fault_q  <= fault_d;
            ej_q     <= ej_d;
            done_q   <= done_d;
            short_q  <= short_d;
        end
    end

    assign chg_ready  = (state_q == IDLE) && !fault_q;
    assign eject_5    = ej_q[0];
    assign eject_10   = ej_q[1];
    assign eject_25   = ej_q[2];
    assign chg_done   = done_q;
    assign chg_short  = short_q;
    assign chg_remain = remain_q;
    assign fault      = fault_q;
    assign overflow   = |ovf;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hand-computed expectations checked with immediate assertions.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset, coin_5, coin_10, coin_25, chg_valid, eject_ack;
    logic [7:0] chg_amount;
    logic       chg_ready, eject_5, eject_10, eject_25, chg_done, chg_short, overflow, fault;
    logic [7:0] chg_remain;
    logic [3:0] tube_5, tube_10, tube_25;
    logic [2:0] ej;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign ej = {eject_25, eject_10, eject_5};

    change_dispenser #(.TUBE_MAX(15), .CNT_W(4), .AMT_W(8), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10), .coin_25(coin_25),
        .chg_valid(chg_valid), .chg_amount(chg_amount), .chg_ready(chg_ready),
        .eject_5(eject_5), .eject_10(eject_10), .eject_25(eject_25), .eject_ack(eject_ack),
        .chg_done(chg_done), .chg_short(chg_short), .chg_remain(chg_remain),
        .overflow(overflow), .fault(fault),
        .tube_5(tube_5), .tube_10(tube_10), .tube_25(tube_25));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        {coin_5, coin_10, coin_25, chg_valid, eject_ack} = '0;
        chg_amount = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic coins(input logic c5, input logic c10, input logic c25);
        {coin_5, coin_10, coin_25} = {c5, c10, c25};
        tick();
        {coin_5, coin_10, coin_25} = 3'b000;
    endtask

    task automatic request(input logic [7:0] amt);
        chg_valid  = 1'b1;
        chg_amount = amt;
        tick();
        chg_valid  = 1'b0;
    endtask

    task automatic wait_eject(input string tag, input logic [2:0] exp);
        int i = 0;
        while (ej == 3'b000 && !chg_done && i < 20) begin tick(); i++; end
        chk(tag, ej, exp);
    endtask

    // Hold the ack off for three cycles of eject, then acknowledge.
    task automatic serve(input string tag);
        tick();
        tick();
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        chk(tag, ej, 3'b000);
    endtask

    task automatic wait_done(input string tag, input logic exp_short, input logic [7:0] exp_rem);
        int   i = 0;
        logic saw_ej = 1'b0;
        while (!chg_done && i < 40) begin
            if (ej != 3'b000) saw_ej = 1'b1;
            tick();
            i++;
        end
        chk({tag, "_done"},   chg_done,   1);
        chk({tag, "_short"},  chg_short,  exp_short);
        chk({tag, "_remain"}, chg_remain, exp_rem);
        chk({tag, "_noej"},   saw_ej,     0);
    endtask

    initial begin
        int hi_cnt, ov_cnt;
        logic saw_done;

        // Reset state
        do_reset();
        chk("rst_ready", chg_ready, 1);
        chk("rst_ej", ej, 0);
        chk("rst_done", chg_done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_remain", chg_remain, 0);
        chk("rst_tubes", {tube_5, tube_10, tube_25}, 0);

        // 1: pay 40 from 25x2, 10x1, 5x1
        coins(1, 1, 1);
        coins(0, 0, 1);
        chk("t1_load", {tube_5, tube_10, tube_25}, {4'd1, 4'd1, 4'd2});
        request(8'd40);
        chk("t1_pick_ready", chg_ready, 0);
        chk("t1_pick_ej", ej, 0);
        tick();
        chk("t1_ej25_lat", ej, 3'b100);
        serve("t1_drop25");
        wait_eject("t1_ej10", 3'b010);
        serve("t1_drop10");
        wait_eject("t1_ej5", 3'b001);
        serve("t1_drop5");
        wait_done("t1", 0, 8'd0);
        chk("t1_tubes", {tube_5, tube_10, tube_25}, {4'd0, 4'd0, 4'd1});

        // 2: empty tubes, 15 cents -> done at N+2, short
        do_reset();
        request(8'd15);
        chk("t2_n1_done", chg_done, 0);
        chk("t2_n1_ej", ej, 0);
        tick();
        chk("t2_n2_done", chg_done, 1);
        chk("t2_short", chg_short, 1);
        chk("t2_remain", chg_remain, 15);
        chk("t2_ej", ej, 0);
        tick();
        chk("t2_ready_again", chg_ready, 1);
        chk("t2_done_pulse", chg_done, 0);

        // 3: greedy is not optimal: 30 from 25x1, 10x3
        coins(0, 1, 1);
        coins(0, 1, 0);
        coins(0, 1, 0);
        chk("t3_load", {tube_10, tube_25}, {4'd3, 4'd1});
        request(8'd30);
        wait_eject("t3_ej25", 3'b100);
        serve("t3_drop25");
        wait_done("t3", 1, 8'd5);
        chk("t3_tubes", {tube_10, tube_25}, {4'd3, 4'd0});

        // 4: ack withheld -> timeout fault
        do_reset();
        coins(0, 1, 0);
        request(8'd10);
        wait_eject("t4_ej10", 3'b010);
        hi_cnt = 1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (chg_done) saw_done = 1'b1;
            if (ej == 3'b000) break;
            hi_cnt++;
        end
        chk("t4_hi_cycles", hi_cnt, 15);
        chk("t4_fault", fault, 1);
        chk("t4_ready", chg_ready, 0);
        chk("t4_no_done", saw_done, 0);
        chk("t4_remain", chg_remain, 10);
        chk("t4_tube10", tube_10, 1);
        coins(1, 0, 0);
        chk("t4_count_in_fault", tube_5, 1);
        request(8'd5);
        tick();
        chk("t4_ignore_req", {ej, chg_done, chg_ready}, 0);
        do_reset();
        chk("t4_rst_fault", fault, 0);
        chk("t4_rst_ready", chg_ready, 1);

        // 5: coin_25 in the ack cycle of eject_25 nets out; saturation of tube_5
        coins(0, 0, 1);
        request(8'd25);
        wait_eject("t5_ej25", 3'b100);
        coin_25   = 1'b1;
        eject_ack = 1'b1;
        tick();
        coin_25   = 1'b0;
        eject_ack = 1'b0;
        chk("t5_tube25_net", tube_25, 1);
        chk("t5_drop", ej, 0);
        chk("t5_ovf_net", overflow, 0);
        wait_done("t5", 0, 8'd0);
        chk("t5_tube25_end", tube_25, 1);
        ov_cnt = 0;
        coin_5 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (overflow) ov_cnt++;
        end
        coin_5 = 1'b0;
        tick();
        if (overflow) ov_cnt++;
        chk("t5_tube5_sat", tube_5, 15);
        chk("t5_ovf_count", ov_cnt, 1);

        // 6a: a second request during EJECT is ignored
        do_reset();
        coins(0, 1, 1);
        request(8'd25);
        wait_eject("t6_ej25", 3'b100);
        chg_valid  = 1'b1;
        chg_amount = 8'd10;
        serve("t6_drop25");
        chg_valid  = 1'b0;
        wait_done("t6", 0, 8'd0);
        tick();
        chk("t6_no_second", ej, 0);
        chk("t6_tubes", {tube_10, tube_25}, {4'd1, 4'd0});

        // 6b: reset while ejecting
        do_reset();
        coins(0, 1, 0);
        request(8'd10);
        wait_eject("t6b_ej10", 3'b010);
        reset = 1'b0;
        tick();
        chk("t6b_ej_low", ej, 0);
        chk("t6b_no_done", chg_done, 0);
        chk("t6b_tubes", {tube_5, tube_10, tube_25}, 0);
        reset = 1'b1;
        tick();
        chk("t6b_idle", {ej, chg_done, chg_ready}, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
